pair_deserializer: RTL and testbench
====================================

# pair_deserializer

Downstream consumer of the two-bit register stage: it samples the `a_i`/`b_i` bit pair that stage produces each clock, packs consecutive pairs into a `WORD_W`-bit word, and presents finished words on a valid/ready output port. A one-word pending buffer absorbs a single stalled word. Any further loss sets a sticky overflow flag.

## Interface
- `WORD_W`, default 8: output word width. Must be even and ≥ 4. Pairs per word `N = WORD_W/2`.
- `clk`  in  1: rising-edge clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clr_i`  in  1: synchronous clear. Resets the same state as `rst_n`.
- `a_i`  in  1: pair bit, more significant.
- `b_i`  in  1: pair bit, less significant.
- `in_valid_i`  in  1: `a_i`/`b_i` hold a pair to capture on this edge.
- `data_o`  out  `WORD_W`: assembled word.
- `valid_o`  out  1: `data_o` holds a word.
- `ready_i`  in  1: downstream accepts `data_o` on this edge.
- `overflow_o`  out  1: sticky flag; a completed word was dropped.

## Operation
- **Reset and clear:** `rst_n`=0 or `clr_i`=1 forces the following, and `clr_i` has priority over all other inputs:
  - pair counter = 0, shift register = 0, pending = 0;
  - `data_o`=0, `valid_o`=0, `overflow_o`=0;
  - FSM = EMPTY.
- **Packing:**
  - On `in_valid_i`=1: shift register ← {shreg[WORD_W-3:0], a_i, b_i}, then pair counter increments.
  - The first pair of a word lands in bits [WORD_W-1:WORD_W-2].
- **Word completion:** `in_valid_i`=1 while counter = N-1.
  - Word = {shreg[WORD_W-3:0], a_i, b_i}.
  - Counter wraps to 0 on the same edge.
- **Drain:** `valid_o`=1 and `ready_i`=1 at the edge.
- **FSM states:**
  - EMPTY: `valid_o`=0.
  - ONE: output register full, pending empty.
  - TWO: output register full, pending full.
- **FSM transitions** (C = completion this edge, D = drain this edge):
  - EMPTY, C → ONE; output ← word.
  - EMPTY, no C → EMPTY. D cannot occur because `valid_o`=0.
  - ONE, C and D → ONE; output ← word.
  - ONE, C only → TWO; pending ← word.
  - ONE, D only → EMPTY.
  - TWO, C and D → TWO; output ← pending, pending ← word.
  - TWO, D only → ONE; output ← pending.
  - TWO, C only → TWO; word dropped, `overflow_o` ← 1. Output and pending are unchanged.
- `overflow_o` stays 1 until reset or `clr_i`. Data flow continues normally while it is set.
- Words leave in completion order. No word is duplicated or reordered.

## Timing
- Latency: `valid_o` rises on the edge that captures the final pair, i.e. one cycle after the final pair is presented.
- `data_o` is registered. It stays stable while `valid_o`=1 and `ready_i`=0.
- `valid_o` never drops without a drain, except on reset or clear.
- Full throughput: one pair per cycle yields one word every N cycles with no stall. `ready_i` may be low for up to N cycles per word without loss.
- Gaps in `in_valid_i` only pause the counter. A partial word is held indefinitely.
- `rst_n` asserted mid-word discards the partial word immediately, without waiting for a clock edge.
- `ready_i` is ignored while `valid_o`=0.

## Test plan
- **Reset values:** assert `rst_n`=0 asynchronously mid-cycle → `data_o`=0, `valid_o`=0, `overflow_o`=0 immediately.
- **Single word:** `WORD_W`=8, `ready_i`=1, pairs (1,0),(1,1),(0,0),(0,1) on 4 consecutive cycles → `data_o`=0xB1, with `valid_o` high for exactly one cycle, one cycle after the 4th pair.
- **Streaming:** 8 consecutive pairs encoding 0xB1 then 0x4E, `ready_i`=1 → `valid_o` pulses at cycles 4 and 8 with 0xB1 and 0x4E.
- **Pending buffer and overflow:**
  - With `ready_i`=0, stream words 0x11, 0x22, 0x33 → `data_o` holds 0x11, `overflow_o`=1 after the 3rd completion.
  - Then set `ready_i`=1 → 0x11 and 0x22 are delivered, and 0x33 never appears.
- **Simultaneous completion and drain in TWO:** with 0x11 in output and 0x22 pending, complete 0x33 on the edge where `ready_i`=1 → next `data_o`=0x22, state stays TWO, and 0x33 follows after the next drain.
- **Clear mid-word:** 2 pairs, then `clr_i`=1 with `in_valid_i`=1, then 4 pairs encoding 0xC3 → `data_o`=0xC3. The partial pairs do not contaminate it, and `overflow_o`=0.

Source files
------------

// File: rtl/pair_deserializer.sv
// Packs consecutive (a_i, b_i) bit pairs into WORD_W-bit words and presents them
// on a valid/ready port backed by a one-word pending buffer and a sticky overflow flag.
module pair_deserializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              a_i,
  input  logic              b_i,
  input  logic              in_valid_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o
);

  localparam int N     = WORD_W / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  // The top pair of the shift register is never read back, so only the low bits are kept.
  logic [WORD_W-3:0] r_shreg;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_pend;
  logic              r_ovf;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_data_next;
  logic [WORD_W-1:0] w_pend_next;
  logic              w_ovf_next;
  logic              w_complete;
  logic              w_drain;

  assign w_word     = {r_shreg, a_i, b_i};
  assign w_complete = in_valid_i && (r_cnt == CNT_W'(N - 1));
  assign w_drain    = (r_state != EMPTY) && ready_i;

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_pend_next  = r_pend;
    w_ovf_next   = r_ovf;
    case (r_state)
      EMPTY: begin
        if (w_complete) begin
          w_state_next = ONE;
          w_data_next  = w_word;
        end
      end
      ONE: begin
        if (w_complete && w_drain) begin
          w_data_next = w_word;
        end else if (w_complete) begin
          w_state_next = TWO;
          w_pend_next  = w_word;
        end else if (w_drain) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_data_next = r_pend;
          if (w_complete) begin
            w_pend_next = w_word;
          end else begin
            w_state_next = ONE;
          end
        end else if (w_complete) begin
          // Both slots full and nothing leaving: the new word is lost.
          w_ovf_next = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else if (clr_i) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_pend  <= w_pend_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (clr_i) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (in_valid_i) begin
      r_shreg <= w_word[WORD_W-3:0];
      r_cnt   <= w_complete ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign data_o     = r_data;
  assign valid_o    = (r_state != EMPTY);
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_pair_deserializer.sv
// Directed bench for pair_deserializer (WORD_W=8): a queue-based model of the
// two-slot output buffer is checked every cycle, plus literal expectations per scenario.
module tb_pair_deserializer;

  logic       clk;
  logic       rst_n;
  logic       clr_i;
  logic       a_i;
  logic       b_i;
  logic       in_valid_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: words currently held (output + pending), partial word, pair count, overflow.
  logic [7:0] mq[$];
  logic [7:0] mword;
  int         mcnt;
  bit         movf;
  // Words actually accepted from the DUT, and the list expected by a scenario.
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  pair_deserializer #(.WORD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .in_valid_i(in_valid_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mword = 8'h00;
    mcnt  = 0;
    movf  = 1'b0;
  endtask

  // One clock: drive inputs, log an accepted word, advance the model on the edge.
  task automatic step(input bit a, input bit b, input bit v, input bit r, input bit c);
    a_i = a; b_i = b; in_valid_i = v; ready_i = r; clr_i = c;
    if (valid_o && r && !c) got.push_back(data_o);
    @(posedge clk);
    if (c) begin
      model_clear();
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (v) begin
        mword = {mword[5:0], a, b};
        mcnt++;
        if (mcnt == 4) begin
          mcnt = 0;
          if (mq.size() < 2) mq.push_back(mword);
          else movf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit r);
    for (int k = 3; k >= 0; k--) step(w[2*k+1], w[2*k], 1'b1, r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic chk_got(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk({nm, "_word"}, 32'(got[k]), 32'(exp_q[k]));
    got.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", 32'(valid_o), 32'(mq.size() > 0));
      chk("cyc_overflow", 32'(overflow_o), 32'(movf));
      if (mq.size() > 0) chk("cyc_data", 32'(data_o), 32'(mq[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr_i = 1'b0; a_i = 1'b0; b_i = 1'b0; in_valid_i = 1'b0; ready_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single word 0xB1, valid for exactly one cycle.
    step(1, 0, 1, 1, 0); step(1, 1, 1, 1, 0); step(0, 0, 1, 1, 0);
    chk("single_not_yet", 32'(valid_o), 32'h0);
    step(0, 1, 1, 1, 0);
    chk("single_valid", 32'(valid_o), 32'h1);
    chk("single_data", 32'(data_o), 32'hB1);
    idle(1, 1'b1);
    chk("single_pulse_end", 32'(valid_o), 32'h0);
    exp_q = '{8'hB1};
    chk_got("single");

    // Back-to-back streaming.
    send_word(8'hB1, 1'b1);
    chk("stream_w0", 32'(data_o), 32'hB1);
    send_word(8'h4E, 1'b1);
    chk("stream_w1", 32'(data_o), 32'h4E);
    idle(2, 1'b1);
    exp_q = '{8'hB1, 8'h4E};
    chk_got("stream");

    // Stalled output: third word overflows.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    chk("ovf_hold_data", 32'(data_o), 32'h11);
    chk("ovf_flag", 32'(overflow_o), 32'h1);
    idle(3, 1'b1);
    chk("ovf_sticky", 32'(overflow_o), 32'h1);
    exp_q = '{8'h11, 8'h22};
    chk_got("ovf_drain");

    // Clear mid-word, with a pair offered on the clearing edge.
    step(1, 1, 1, 1, 0); step(0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    send_word(8'hC3, 1'b1);
    chk("clr_data", 32'(data_o), 32'hC3);
    chk("clr_overflow", 32'(overflow_o), 32'h0);
    idle(1, 1'b1);
    exp_q = '{8'hC3};
    chk_got("clr");

    // Completion and drain on the same edge while two words are held.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    step(0, 0, 1, 0, 0); step(1, 1, 1, 0, 0); step(0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("cd_data", 32'(data_o), 32'h22);
    chk("cd_overflow", 32'(overflow_o), 32'h0);
    idle(1, 1'b0);
    chk("cd_hold", 32'(data_o), 32'h22);
    idle(1, 1'b1);
    chk("cd_next", 32'(data_o), 32'h33);
    chk("cd_next_valid", 32'(valid_o), 32'h1);
    idle(2, 1'b1);
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_got("cd");

    // Asynchronous reset mid-cycle with full buffers, overflow and a partial word.
    send_word(8'h55, 1'b0);
    send_word(8'h66, 1'b0);
    send_word(8'h77, 1'b0);
    step(1, 0, 1, 0, 0); step(1, 0, 1, 0, 0);
    chk("pre_rst_overflow", 32'(overflow_o), 32'h1);
    a_i = 1'b0; b_i = 1'b0; in_valid_i = 1'b0; ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_data", 32'(data_o), 32'h0);
    chk("async_rst_valid", 32'(valid_o), 32'h0);
    chk("async_rst_overflow", 32'(overflow_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h5A, 1'b1);
    chk("post_rst_data", 32'(data_o), 32'h5A);
    idle(1, 1'b1);
    exp_q = '{8'h5A};
    chk_got("post_rst");

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
